// File: rtl/blob_counter_cc_if.sv
// Pixel-stream and result bundle for blob_counter_cc.
// The camera side drives i_*; the counter drives o_*.
interface blob_counter_cc_if #(
  parameter int COUNT_W = 8
) ();
  logic               i_valid;
  logic               i_seq;
  logic               o_valid;
  logic [COUNT_W-1:0] o_count;
  logic               o_overflow;
  logic               o_busy;

  modport master (
    output i_valid, i_seq,
    input  o_valid, o_count, o_overflow, o_busy
  );

  modport slave (
    input  i_valid, i_seq,
    output o_valid, o_count, o_overflow, o_busy
  );
endinterface

// File: rtl/blob_counter_cc.sv
// Single-pass streaming connected-component counter.
// Flat union table, one pixel per cycle, one count per frame.
module blob_counter_cc #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int MAX_LABELS = 64,
  parameter int COUNT_W    = 8,
  parameter bit CONN8      = 1'b0
) (
  input logic              i_clk,
  input logic              i_rst_n,
  blob_counter_cc_if.slave bus
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int LW = $clog2(MAX_LABELS + 1);

  typedef logic [LW-1:0] lbl_t;

  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);
  localparam lbl_t          LMAX = LW'(MAX_LABELS);
  localparam logic [32:0]   CMAX = (33'd1 << COUNT_W) - 33'd1;

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  lbl_t          left_q, ul_q;
  lbl_t          lb   [WIDTH];
  lbl_t          root [MAX_LABELS+1];
  lbl_t          alloc_q, merge_q;
  logic          ovf_q;
  logic          busy_q, valid_q, ovf_out_q;
  logic [COUNT_W-1:0] count_q;

  logic          xl, xr, y0, last;
  logic [XW-1:0] ur_idx;
  lbl_t          l_raw, ul_raw, up_raw, ur_raw;
  lbl_t          r [4];
  lbl_t          a, b, cur;
  logic          need_new, full, do_merge;
  lbl_t          alloc_n, merge_n;
  logic          ovf_n;
  logic [32:0]   diff;
  logic [COUNT_W-1:0] count_n;

  always_comb begin
    xl     = (x_q == '0);
    xr     = (x_q == XMAX);
    y0     = (y_q == '0);
    last   = bus.i_valid && xr && (y_q == YMAX);
    ur_idx = xr ? x_q : x_q + XW'(1);
    up_raw = y0 ? '0 : lb[x_q];
    ur_raw = (y0 || xr || !CONN8) ? '0 : lb[ur_idx];
    l_raw  = xl ? '0 : left_q;
    ul_raw = (xl || !CONN8) ? '0 : ul_q;
    r[0]   = root[l_raw];
    r[1]   = root[ul_raw];
    r[2]   = root[up_raw];
    r[3]   = root[ur_raw];
    // a = smallest foreground root, b = largest; they differ only on a merge
    a = '0;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      if (r[i] != '0) begin
        if (a == '0 || r[i] < a) a = r[i];
        if (r[i] > b) b = r[i];
      end
    end
    need_new = bus.i_seq && (a == '0);
    full     = (alloc_q == LMAX);
    do_merge = bus.i_seq && (b != a);
    cur      = '0;
    if (bus.i_seq) begin
      if (a != '0)  cur = a;
      else if (!full) cur = alloc_q + LW'(1);
    end
    alloc_n = alloc_q + LW'(need_new && !full);
    merge_n = merge_q + LW'(do_merge);
    ovf_n   = ovf_q | (need_new && full);
    diff    = 33'(alloc_n) - 33'(merge_n);
    count_n = (diff > CMAX) ? COUNT_W'(CMAX) : COUNT_W'(diff);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      left_q    <= '0;
      ul_q      <= '0;
      alloc_q   <= '0;
      merge_q   <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      ovf_out_q <= 1'b0;
      count_q   <= '0;
      for (int k = 0; k <= MAX_LABELS; k++) root[k] <= lbl_t'(k);
    end else begin
      valid_q <= 1'b0;
      if (last) begin
        x_q       <= '0;
        y_q       <= '0;
        alloc_q   <= '0;
        merge_q   <= '0;
        ovf_q     <= 1'b0;
        busy_q    <= 1'b0;
        valid_q   <= 1'b1;
        ovf_out_q <= ovf_n;
        count_q   <= count_n;
        for (int k = 0; k <= MAX_LABELS; k++) root[k] <= lbl_t'(k);
      end else if (bus.i_valid) begin
        lb[x_q] <= cur;
        left_q  <= cur;
        ul_q    <= up_raw;
        alloc_q <= alloc_n;
        merge_q <= merge_n;
        ovf_q   <= ovf_n;
        busy_q  <= 1'b1;
        // keep the table flat: every entry pointing at b now points at a
        for (int k = 0; k <= MAX_LABELS; k++)
          if (do_merge && root[k] == b) root[k] <= a;
        if (xr) begin
          x_q <= '0;
          y_q <= y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end
    end
  end

  assign bus.o_valid    = valid_q;
  assign bus.o_count    = count_q;
  assign bus.o_overflow = ovf_out_q;
  assign bus.o_busy     = busy_q;
endmodule

// File: tb/tb_blob_counter_cc.sv
// Bench for blob_counter_cc: three 8x6 instances (4-conn, 8-conn,
// 3-bit count) fed the same pixel stream, checked per frame.
module tb_blob_counter_cc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tv = 1'b0;
  logic ts = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   pulses = 0;
  int   frames = 0;

  always #5 clk = ~clk;

  blob_counter_cc_if #(.COUNT_W(8)) ia ();
  blob_counter_cc_if #(.COUNT_W(8)) ib ();
  blob_counter_cc_if #(.COUNT_W(3)) ic ();

  assign ia.i_valid = tv;
  assign ia.i_seq   = ts;
  assign ib.i_valid = tv;
  assign ib.i_seq   = ts;
  assign ic.i_valid = tv;
  assign ic.i_seq   = ts;

  blob_counter_cc #(.WIDTH(8), .HEIGHT(6), .MAX_LABELS(16),
    .COUNT_W(8), .CONN8(1'b0))
  dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(ia));

  blob_counter_cc #(.WIDTH(8), .HEIGHT(6), .MAX_LABELS(16),
    .COUNT_W(8), .CONN8(1'b1))
  dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(ib));

  blob_counter_cc #(.WIDTH(8), .HEIGHT(6), .MAX_LABELS(16),
    .COUNT_W(3), .CONN8(1'b0))
  dut_c (.i_clk(clk), .i_rst_n(rst_n), .bus(ic));

  always @(posedge clk) if (ia.o_valid) pulses++;

  typedef struct {
    string       name;
    logic [47:0] pat;
    bit          gaps;
    int          ca, oa, cb, ob, cc, oc;
  } vec_t;

  vec_t v[10];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic send(input logic s, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        tv = 1'b0;
        @(posedge clk); #1;
      end
    end
    tv = 1'b1;
    ts = s;
    @(posedge clk); #1;
    tv = 1'b0;
    ts = 1'b0;
  endtask

  task automatic run_frame(input vec_t t);
    int early;
    early = 0;
    for (int i = 0; i < 48; i++) begin
      send(t.pat[i], t.gaps);
      if (i == 0) chk({t.name, " busy_first"}, int'(ia.o_busy), 1);
      if (i < 47 && (ia.o_valid || ib.o_valid || ic.o_valid)) early++;
    end
    frames++;
    chk({t.name, " early_valid"}, early, 0);
    chk({t.name, " valid"}, int'(ia.o_valid & ib.o_valid & ic.o_valid), 1);
    chk({t.name, " busy_end"}, int'(ia.o_busy | ib.o_busy | ic.o_busy), 0);
    chk({t.name, " count_a"}, int'(ia.o_count), t.ca);
    chk({t.name, " ovf_a"}, int'(ia.o_overflow), t.oa);
    chk({t.name, " count_b"}, int'(ib.o_count), t.cb);
    chk({t.name, " ovf_b"}, int'(ib.o_overflow), t.ob);
    chk({t.name, " count_c"}, int'(ic.o_count), t.cc);
    chk({t.name, " ovf_c"}, int'(ic.o_overflow), t.oc);
    @(posedge clk); #1;
    chk({t.name, " pulse_end"}, int'(ia.o_valid | ib.o_valid | ic.o_valid), 0);
    chk({t.name, " count_hold"}, int'(ia.o_count), t.ca);
  endtask

  initial begin
    // rows packed {row5..row0}; bit x of each byte is pixel x
    v[0] = '{"zero",   {8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, 0,0, 0,0, 0,0};
    v[1] = '{"squares",{8'h00,8'h06,8'h06,8'h00,8'h33,8'h33}, 0, 3,0, 3,0, 3,0};
    v[2] = '{"ushape", {8'h00,8'h1E,8'h12,8'h12,8'h12,8'h12}, 0, 1,0, 1,0, 1,0};
    v[3] = '{"diag",   {8'h00,8'h00,8'h00,8'h04,8'h02,8'h00}, 0, 2,0, 1,0, 2,0};
    v[4] = '{"checker",{8'hAA,8'h55,8'hAA,8'h55,8'hAA,8'h55}, 0, 16,1, 1,0, 7,1};
    v[5] = '{"zero2",  {8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, 0,0, 0,0, 0,0};
    v[6] = '{"iso10",  {8'h00,8'h05,8'h00,8'h55,8'h00,8'h55}, 0, 10,0, 10,0, 7,0};
    v[7] = '{"iso10g", {8'h00,8'h05,8'h00,8'h55,8'h00,8'h55}, 1, 10,0, 10,0, 7,0};
    v[8] = '{"wrap",   {8'h00,8'h00,8'h00,8'h01,8'h80,8'h00}, 0, 2,0, 2,0, 2,0};
    v[9] = '{"ushapeg",{8'h00,8'h1E,8'h12,8'h12,8'h12,8'h12}, 1, 1,0, 1,0, 1,0};

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst valid", int'(ia.o_valid | ib.o_valid | ic.o_valid), 0);
    chk("rst count", int'(ia.o_count) + int'(ib.o_count) + int'(ic.o_count), 0);
    chk("rst ovf", int'(ia.o_overflow | ib.o_overflow | ic.o_overflow), 0);
    chk("rst busy", int'(ia.o_busy | ib.o_busy | ic.o_busy), 0);

    for (int i = 0; i < 10; i++) run_frame(v[i]);

    // abort a partial frame with a one-cycle reset
    for (int i = 0; i < 20; i++) send(1'b1, 1'b0);
    chk("abort busy", int'(ia.o_busy), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort rst busy", int'(ia.o_busy), 0);
    chk("abort rst count", int'(ia.o_count), 0);
    run_frame('{"after_rst", {8'h00,8'h00,8'hC0,8'h00,8'h00,8'h03},
                0, 2,0, 2,0, 2,0});

    repeat (3) @(posedge clk);
    #1;
    chk("pulse count", pulses, frames);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
